// File: rtl/receiver_pkg.sv
// rtl/receiver_pkg.sv - shared types and constants for the serial receiver
package receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam bit PARITY_EVEN = 1'b1;

endpackage

// File: rtl/receiver_if.sv
// rtl/receiver_if.sv - serial line input and parallel result bus of the receiver
interface receiver_if;
  logic       enable;
  logic       data_in;
  logic [7:0] data_bus;
  logic       busy;
  logic       err;

  modport master (
    output enable, data_in,
    input  data_bus, busy, err
  );

  modport slave (
    input  enable, data_in,
    output data_bus, busy, err
  );
endinterface

// File: rtl/receiver_bit_timer.sv
// rtl/receiver_bit_timer.sv - bit-period tick counter producing mid-bit sample strobes
module rx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic sample
);

  generate
    if (CLKS_PER_BIT == 1) begin : g_one
      // Every clock is a bit period, so every clock is a sample point.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, load};
      assign sample = 1'b1;
    end else begin : g_cnt
      localparam int CW = $clog2(CLKS_PER_BIT);
      logic [CW-1:0] cnt;

      // Load lands the first strobe half a bit after detection, then one per bit period.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= CW'(CLKS_PER_BIT / 2 - 1);
        end else if (cnt == '0) begin
          cnt <= CW'(CLKS_PER_BIT - 1);
        end else begin
          cnt <= cnt - 1'b1;
        end
      end

      assign sample = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - UART-style frame receiver: start, 8 data LSB-first, even parity, stop
module receiver
  import receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      clk,
  input  logic      rst,
  receiver_if.slave bus
);

  rx_state_t            state_q, state_n;
  logic [2:0]           count_q, count_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 perr_q, perr_n;
  logic [7:0]           data_bus_q, data_bus_n;
  logic                 busy_q, busy_n;
  logic                 err_q, err_n;
  logic                 load;
  logic                 sample;

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .sample (sample)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_bus_q <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      shift_q    <= shift_n;
      perr_q     <= perr_n;
      data_bus_q <= data_bus_n;
      busy_q     <= busy_n;
      err_q      <= err_n;
    end
  end

  // Frame sequencing, data capture, parity/stop checks; enable low aborts any frame.
  always_comb begin
    state_n    = state_q;
    count_n    = count_q;
    shift_n    = shift_q;
    perr_n     = perr_q;
    data_bus_n = data_bus_q;
    err_n      = err_q;
    load       = 1'b0;

    if (state_q == IDLE) begin
      if (bus.enable && !bus.data_in) begin
        load    = 1'b1;
        count_n = '0;
        // With one clock per bit the detection sample already is the start check.
        state_n = (CLKS_PER_BIT == 1) ? DATA : START;
      end
    end else if (!bus.enable) begin
      state_n = IDLE;
    end else if (sample) begin
      case (state_q)
        START: begin
          count_n = '0;
          state_n = bus.data_in ? IDLE : DATA;
        end
        DATA: begin
          shift_n[count_q] = bus.data_in;
          count_n          = count_q + 3'd1;
          if (count_q == 3'(DATA_BITS - 1)) state_n = PARITY;
        end
        PARITY: begin
          perr_n  = bus.data_in ^ (^shift_q) ^ !PARITY_EVEN;
          state_n = STOP;
        end
        STOP: begin
          if (bus.data_in && !perr_q) begin
            data_bus_n = shift_q;
            err_n      = 1'b0;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.data_bus = data_bus_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - directed, table-driven checks of the serial receiver
module tb_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  receiver_if if1 ();
  receiver_if if4 ();

  receiver #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  receiver #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_bus;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else passed++;
  endtask

  task automatic set_line(input int cpb, input logic v);
    if (cpb == 1) if1.data_in = v;
    else          if4.data_in = v;
  endtask

  task automatic get_busy(input int cpb, output logic b);
    b = (cpb == 1) ? if1.busy : if4.busy;
  endtask

  // Drives one full frame; the first edge after the start bit goes low is the detection edge.
  task automatic send_frame(input int cpb, input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    logic        b;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      set_line(cpb, bits[i]);
      for (int c = 0; c < cpb; c++) begin
        tick();
        if (cpb == 1 && (i == 0 || i == 9)) begin
          get_busy(cpb, b);
          chk($sformatf("busy_mid_bit%0d", i), {7'b0, b}, 8'h01);
        end
      end
    end
    set_line(cpb, 1'b1);
    get_busy(cpb, b);
    chk("busy_after_stop", {7'b0, b}, 8'h00);
  endtask

  initial begin
    vecs[0] = '{8'hAE, 1'b1, 1'b1, 8'hAE, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 8'hAE, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hAE, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};

    if1.enable = 1'b1; if1.data_in = 1'b1;
    if4.enable = 1'b1; if4.data_in = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_bus",  if1.data_bus, 8'h00);
    chk("rst_busy", {7'b0, if1.busy}, 8'h00);
    chk("rst_err",  {7'b0, if1.err}, 8'h00);
    chk("rst_bus4", if4.data_bus, 8'h00);

    // Back-to-back frames, no idle gap between them.
    for (int v = 0; v < 8; v++) begin
      send_frame(1, vecs[v].data, vecs[v].par, vecs[v].stop);
      chk($sformatf("vec%0d_bus", v), if1.data_bus, vecs[v].exp_bus);
      chk($sformatf("vec%0d_err", v), {7'b0, if1.err}, {7'b0, vecs[v].exp_err});
    end

    // Disabled receiver ignores a start bit.
    tick();
    if1.enable = 1'b0;
    if1.data_in = 1'b0;
    tick(); tick(); tick();
    chk("dis_busy", {7'b0, if1.busy}, 8'h00);
    if1.data_in = 1'b1;
    tick();
    if1.enable = 1'b1;
    tick();
    chk("dis_busy_after", {7'b0, if1.busy}, 8'h00);

    // Abort after data bit 3 of 8'h0F.
    if1.data_in = 1'b0;
    tick();
    chk("abort_busy_start", {7'b0, if1.busy}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      if1.data_in = 1'b1;
      tick();
    end
    if1.enable = 1'b0;
    tick();
    chk("abort_busy", {7'b0, if1.busy}, 8'h00);
    chk("abort_bus",  if1.data_bus, 8'h80);
    chk("abort_err",  {7'b0, if1.err}, 8'h00);
    if1.enable = 1'b1;
    if1.data_in = 1'b1;
    tick(); tick();
    chk("abort_idle", {7'b0, if1.busy}, 8'h00);
    send_frame(1, 8'hC3, 1'b0, 1'b1);
    chk("post_abort_bus", if1.data_bus, 8'hC3);

    // Four clocks per bit.
    send_frame(4, 8'hA5, 1'b0, 1'b1);
    chk("cpb4_bus", if4.data_bus, 8'hA5);
    chk("cpb4_err", {7'b0, if4.err}, 8'h00);

    // One-clock glitch is rejected at the mid-bit start check.
    tick();
    if4.data_in = 1'b0;
    tick();
    if4.data_in = 1'b1;
    chk("glitch_busy_detect", {7'b0, if4.busy}, 8'h01);
    tick(); tick(); tick();
    chk("glitch_busy", {7'b0, if4.busy}, 8'h00);
    chk("glitch_bus",  if4.data_bus, 8'hA5);
    chk("glitch_err",  {7'b0, if4.err}, 8'h00);

    // Parity error at four clocks per bit.
    send_frame(4, 8'h12, 1'b1, 1'b1);
    chk("cpb4_perr_err", {7'b0, if4.err}, 8'h01);
    chk("cpb4_perr_bus", if4.data_bus, 8'hA5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
